// File: rtl/seg7_capture.sv
// Seven-segment capture: debounces the segment lines, decodes each stable
// glyph to a hex nibble and queues it in a small first-word-fall-through FIFO.
module seg7_capture #(
  parameter int STABLE_CYCLES = 1000,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [6:0]                    segments_in,
  output logic [3:0]                    digit_data,
  output logic                          digit_valid,
  input  logic                          digit_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          bad_glyph
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = AW + 1;

  localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [NW-1:0] FULL_CNT = NW'(FIFO_DEPTH);

  logic [6:0]    seg_q, seg_d;
  logic [6:0]    cand_q, cand_d;
  logic [6:0]    last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [NW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          bad_q, bad_d;
  logic [3:0]    mem_q [FIFO_DEPTH];
  logic [3:0]    mem_d [FIFO_DEPTH];

  logic          accept;
  logic          glyph_ok;
  logic [3:0]    glyph_nib;
  logic          full;
  logic          pop;
  logic          push;

  always_comb begin
    glyph_ok  = 1'b1;
    glyph_nib = 4'h0;
    unique case (cand_q)
      7'h3F: glyph_nib = 4'h0;
      7'h06: glyph_nib = 4'h1;
      7'h5B: glyph_nib = 4'h2;
      7'h4F: glyph_nib = 4'h3;
      7'h66: glyph_nib = 4'h4;
      7'h6D: glyph_nib = 4'h5;
      7'h7D: glyph_nib = 4'h6;
      7'h07: glyph_nib = 4'h7;
      7'h7F: glyph_nib = 4'h8;
      7'h6F: glyph_nib = 4'h9;
      7'h77: glyph_nib = 4'hA;
      7'h7C: glyph_nib = 4'hB;
      7'h39: glyph_nib = 4'hC;
      7'h5E: glyph_nib = 4'hD;
      7'h79: glyph_nib = 4'hE;
      7'h71: glyph_nib = 4'hF;
      default: glyph_ok = 1'b0;
    endcase
  end

  always_comb begin
    seg_d   = segments_in;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    bad_d   = bad_q;
    mem_d   = mem_q;

    if (seg_q != cand_q) begin
      cand_d = seg_q;
      cnt_d  = CW'(1);
    end else if (cnt_q < CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end

    // Fires once per new pattern, on the edge the count saturates.
    accept = (seg_q == cand_q) && (cnt_q == CNT_LAST) &&
             (cand_q != last_q);

    full = (count_q == FULL_CNT);
    pop  = (count_q != '0) && digit_ready;
    push = accept && glyph_ok && (!full || pop);

    if (accept) last_d = cand_q;
    if (accept && glyph_ok && full && !pop) ovf_d = 1'b1;
    if (accept && !glyph_ok && cand_q != 7'h00) bad_d = 1'b1;

    if (push) begin
      mem_d[wr_q] = glyph_nib;
      wr_d        = wr_q + 1'b1;
    end
    if (pop) rd_d = rd_q + 1'b1;

    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q   <= 7'h00;
      cand_q  <= 7'h00;
      last_q  <= 7'h00;
      cnt_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      seg_q   <= seg_d;
      cand_q  <= cand_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      bad_q   <= bad_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign digit_valid = (count_q != '0);
  assign digit_data  = digit_valid ? mem_q[rd_q] : 4'h0;
  assign fifo_count  = count_q;
  assign overflow    = ovf_q;
  assign bad_glyph   = bad_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Bench for seg7_capture: scoreboard of expected nibbles, popped and
// compared whenever the consumer takes the FIFO head.
module tb_seg7_capture;

  logic       clk;
  logic       rst;
  logic [6:0] segments_in;
  logic [3:0] digit_data;
  logic       digit_valid;
  logic       digit_ready;
  logic [2:0] fifo_count;
  logic       overflow;
  logic       bad_glyph;

  int n_checks;
  int n_fail;
  logic [3:0] sb_q[$];
  logic [6:0] glyph_tbl [16];

  seg7_capture #(.STABLE_CYCLES(1000), .FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .segments_in (segments_in),
    .digit_data  (digit_data),
    .digit_valid (digit_valid),
    .digit_ready (digit_ready),
    .fifo_count  (fifo_count),
    .overflow    (overflow),
    .bad_glyph   (bad_glyph)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change #1 after posedge, so the head is stable at negedge.
  always @(negedge clk) begin
    if (!rst && digit_valid && digit_ready) begin
      if (sb_q.size() == 0) check("sb_underflow", 1, 0);
      else check("pop_data", int'(digit_data), int'(sb_q.pop_front()));
    end
  end

  task automatic hold(input logic [6:0] pat, input int n);
    segments_in = pat;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    digit_ready = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    digit_ready = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_count"}, int'(fifo_count), 0);
    check({tag, "_sb"}, sb_q.size(), 0);
  endtask

  initial begin
    #(10 * 80000);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    glyph_tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    n_checks    = 0;
    n_fail      = 0;
    rst         = 1'b1;
    segments_in = 7'h00;
    digit_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_valid", int'(digit_valid), 0);
    check("rst_data", int'(digit_data), 0);
    check("rst_count", int'(fifo_count), 0);
    check("rst_ovf", int'(overflow), 0);
    check("rst_bad", int'(bad_glyph), 0);

    // Basic capture with exact latency
    hold(7'h5B, 1000);
    check("lat_early", int'(digit_valid), 0);
    @(posedge clk);
    #1;
    check("lat_valid", int'(digit_valid), 1);
    check("lat_data", int'(digit_data), 2);
    sb_q.push_back(4'h2);
    hold(7'h5B, 199);
    check("basic_count", int'(fifo_count), 1);
    drain(5);
    check_idle("basic");

    // One cycle short of the threshold
    hold(7'h06, 999);
    hold(7'h00, 1200);
    check("glitch_count", int'(fifo_count), 0);
    check("glitch_valid", int'(digit_valid), 0);
    check("glitch_bad", int'(bad_glyph), 0);

    // Blank separation re-arms repeats
    hold(7'h5B, 1100);
    hold(7'h00, 1100);
    hold(7'h5B, 1100);
    hold(7'h00, 1100);
    hold(7'h4F, 1100);
    sb_q.push_back(4'h2);
    sb_q.push_back(4'h2);
    sb_q.push_back(4'h3);
    check("rep_count", int'(fifo_count), 3);
    drain(6);
    check_idle("rep");
    digit_ready = 1'b1;
    sb_q.push_back(4'h2);
    hold(7'h5B, 3000);
    digit_ready = 1'b0;
    check_idle("long");

    // Invalid glyph, then a valid one
    hold(7'h49, 1100);
    check("bad_flag", int'(bad_glyph), 1);
    check("bad_count", int'(fifo_count), 0);
    hold(7'h7F, 1100);
    sb_q.push_back(4'h8);
    check("after_bad_count", int'(fifo_count), 1);
    drain(3);
    check_idle("after_bad");

    // Overflow: five digits into four slots
    for (int d = 1; d <= 5; d++) begin
      hold(glyph_tbl[d], 1100);
      hold(7'h00, 1100);
      if (d <= 4) sb_q.push_back(4'(d));
    end
    check("ovf_count", int'(fifo_count), 4);
    check("ovf_flag", int'(overflow), 1);
    // Push and pop on the same edge while full
    hold(glyph_tbl[6], 1000);
    digit_ready = 1'b1;
    @(posedge clk);
    #1;
    digit_ready = 1'b0;
    sb_q.push_back(4'h6);
    check("fullpp_count", int'(fifo_count), 4);
    hold(glyph_tbl[6], 100);
    drain(6);
    check_idle("ovf");
    check("ovf_sticky", int'(overflow), 1);

    // Reset mid-settle with entries queued
    hold(7'h3F, 1100);
    hold(7'h00, 1100);
    hold(7'h06, 1100);
    hold(7'h00, 1100);
    check("pre_rst_count", int'(fifo_count), 2);
    hold(7'h6F, 500);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb_q.delete();
    check("mid_valid", int'(digit_valid), 0);
    check("mid_data", int'(digit_data), 0);
    check("mid_count", int'(fifo_count), 0);
    check("mid_ovf", int'(overflow), 0);
    check("mid_bad", int'(bad_glyph), 0);
    repeat (1000) @(posedge clk);
    #1;
    check("rst_lat_early", int'(digit_valid), 0);
    @(posedge clk);
    #1;
    check("rst_lat_valid", int'(digit_valid), 1);
    check("rst_lat_data", int'(digit_data), 9);
    sb_q.push_back(4'h9);
    drain(3);
    check_idle("final");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
